seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed 4-digit seven-segment driver downstream of the pipeline core.
//   Consumes the 16-bit result word through a valid/ready update port.
//   Produces the anode (AN) and segment (BCD) board outputs.
//   Adds tear-free frame-boundary updates, leading-zero blanking, per-digit
//   decimal points and PWM brightness control.
// PARAMETERS
//   DIV_BITS   15   scan divider width; one digit slot = 2**DIV_BITS clk cycles (must be >= 4)
//   PWM_BITS   4    brightness resolution; sub-slot index = top PWM_BITS bits of divider
// PORTS
//   clk           in   1   single system clock, rising edge
//   reset         in   1   asynchronous, active-low reset
//   enable        in   1   1 = drive display; 0 = all digits off
//   bright        in   4   duty = (bright+1)/16 of each digit slot
//   upd_valid     in   1   new display word offered
//   upd_ready     out  1   pending buffer empty, can accept
//   upd_value     in   16  hex value; [3:0] = digit 0 (rightmost)
//   upd_dp        in   4   decimal point per digit, 1 = lit
//   upd_blank_lz  in   1   1 = blank leading zeros
//   AN            out  4   anodes, active-low, AN[0] = rightmost
//   BCD           out  8   segments, active-low, {dp,g,f,e,d,c,b,a}
//   frame_done    out  1   1-cycle pulse at end of digit-3 slot
// BEHAVIOUR
//   Reset values: AN=4'hF, BCD=8'hFF, upd_ready=1, frame_done=0.
//     Also: div=0, digit index=0, shown value/dp/blank_lz=0, pending empty.
//   Reset asserted mid-operation clears everything immediately; any pending word is dropped.
//   Scan:
//     - div counts 0..2**DIV_BITS-1 and wraps.
//     - At terminal count the digit index advances 0->1->2->3->0.
//   Update handshake:
//     - Transfer occurs when upd_valid && upd_ready.
//     - The word goes to the pending register; upd_ready falls the next cycle.
//   Frame boundary = digit index 3 && div terminal.
//     - frame_done=1 in that cycle.
//     - If pending is full, it is copied to the shown registers on that edge.
//     - Pending clears; upd_ready=1 the following cycle.
//   Simultaneous accept and boundary with pending empty: the word is accepted into
//     pending and applied at the NEXT boundary, never mid-frame.
//   upd_valid held while upd_ready=0 has no effect; the sender must hold the data.
//   Blanking: digit i (i=1..3) is blanked iff all of the following hold:
//     - blank_lz=1;
//     - shown nibbles i..3 are all 0;
//     - dp[i]=0.
//     Digit 0 is never blanked.
//   Anode for the current digit is active (low) iff all of the following hold:
//     - enable=1;
//     - the digit is not blanked;
//     - sub <= bright, where sub = div[DIV_BITS-1 -: PWM_BITS].
//     Otherwise AN=4'hF and BCD=8'hFF.
//   Segment table, hex digit -> BCD[6:0] (active-low, g..a):
//     0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
//   BCD[7] = ~dp[index].
//   AN, BCD and frame_done are registered: they reflect the divider/index state
//     one cycle later.
//   enable=0 does not stop the divider, the index or the handshake; frame
//     boundaries still apply updates.
// STRUCTURE
//   seg7_pkg:
//     - DIGITS=4 localparam;
//     - SEG_OFF=8'hFF, AN_OFF=4'hF;
//     - function hex_to_seg(nibble) returning 7-bit active-low code.
//   One sub-module: seg7_hex_decode (combinational nibble+dp -> BCD), instanced once on the muxed nibble.
//   Top: divider/index counters, pending + shown registers, blank logic, output registers.
// TESTING  (bench uses DIV_BITS=4: slot = 16 cycles, PWM sub = div[3:0])
//   1. Reset release, enable=1, bright=15, value 0
//      -> AN steps E,D,B,7 every 16 cycles; BCD=C0 throughout.
//   2. Mid-frame send 16'h12AB
//      -> upd_ready falls; display unchanged until frame_done.
//      -> Then digits 0..3 show 83,88,A4,F9; upd_ready=1 next cycle.
//   3. Send 16'h0045 with blank_lz=1, dp=0 -> AN[3],AN[2] stay 1.
//      Send 16'h0000 -> only AN[0] low, BCD=C0.
//      Send 16'h0005 with dp=4'b0010 -> digit1 BCD=40.
//   4. bright=3 -> each active anode low for exactly 4 of its 16 cycles (div 0..3).
//      enable=0 -> AN=F, BCD=FF.
//   5. Back-to-back: two words, second valid held
//      -> second accepted on the cycle after the boundary; first shown one full frame.
//   6. reset low mid-slot with pending full
//      -> AN=F, BCD=FF, upd_ready=1 with no clock edge.
//      -> After release, display shows 0 (pending discarded).

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and hex-to-segment lookup for the scan driver
// Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam int         DIGITS  = 4;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decode
// Description : Combinational nibble + decimal point to active-low segment byte
// Revision    : 1.0  initial release
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    assign o_seg = {~i_dp, hex_to_seg(i_nibble)};

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : 4-digit multiplexed seven-segment driver with frame-synchronous
//               updates, leading-zero blanking, decimal points and PWM dimming
// Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV_BITS = 15,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] bright,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [15:0]         upd_value,
    input  logic [DIGITS-1:0]   upd_dp,
    input  logic                upd_blank_lz,
    output logic [DIGITS-1:0]   AN,
    output logic [7:0]          BCD,
    output logic                frame_done
);

    localparam int IDX_W = $clog2(DIGITS);

    logic [DIV_BITS-1:0] r_div;
    logic [IDX_W-1:0]    r_idx;

    logic                r_pend_full;
    logic [15:0]         r_pend_value;
    logic [DIGITS-1:0]   r_pend_dp;
    logic                r_pend_blz;

    logic [15:0]         r_shown_value;
    logic [DIGITS-1:0]   r_shown_dp;
    logic                r_shown_blz;

    logic                w_div_tc;
    logic                w_boundary;
    logic                w_accept;
    logic [PWM_BITS-1:0] w_sub;
    logic [DIGITS-1:0]   w_digit_blank;
    logic [3:0]          w_nibble;
    logic                w_dp;
    logic                w_lit;
    logic [7:0]          w_seg;

    assign w_div_tc   = &r_div;
    assign w_boundary = w_div_tc && (r_idx == IDX_W'(DIGITS - 1));
    assign upd_ready  = ~r_pend_full;
    assign w_accept   = upd_valid && upd_ready;
    assign w_sub      = r_div[DIV_BITS-1 -: PWM_BITS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
            r_idx <= '0;
        end else begin
            r_div <= r_div + 1'b1;
            if (w_div_tc) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Shown registers only change on a frame boundary so a frame never tears;
    // a word accepted on the boundary edge itself waits for the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_full   <= 1'b0;
            r_pend_value  <= '0;
            r_pend_dp     <= '0;
            r_pend_blz    <= 1'b0;
            r_shown_value <= '0;
            r_shown_dp    <= '0;
            r_shown_blz   <= 1'b0;
        end else if (w_boundary && r_pend_full) begin
            r_shown_value <= r_pend_value;
            r_shown_dp    <= r_pend_dp;
            r_shown_blz   <= r_pend_blz;
            r_pend_full   <= 1'b0;
        end else if (w_accept) begin
            r_pend_value  <= upd_value;
            r_pend_dp     <= upd_dp;
            r_pend_blz    <= upd_blank_lz;
            r_pend_full   <= 1'b1;
        end
    end

    // A digit is a leading zero when it and every digit to its left are zero
    assign w_digit_blank[0] = 1'b0;
    for (genvar i = 1; i < DIGITS; i++) begin : g_blank
        assign w_digit_blank[i] = r_shown_blz && !r_shown_dp[i] &&
                                  (r_shown_value[4*DIGITS-1 : 4*i] == '0);
    end

    assign w_nibble = r_shown_value[{r_idx, 2'b00} +: 4];
    assign w_dp     = r_shown_dp[r_idx];
    assign w_lit    = enable && !w_digit_blank[r_idx] && (w_sub <= bright);

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .i_dp     (w_dp),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AN         <= AN_OFF;
            BCD        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_boundary;
            if (w_lit) begin
                AN  <= ~(DIGITS'(1) << r_idx);
                BCD <= w_seg;
            end else begin
                AN  <= AN_OFF;
                BCD <= SEG_OFF;
            end
        end
    end

endmodule
`default_nettype wire
